gpio_irq_arbiter: RTL and testbench
===================================

// Module: gpio_irq_arbiter
// PURPOSE
//  Collects per-pin INTR levels from the GPIO pin mux and arbitrates them round-robin.
//  Presents one interrupt at a time to the CPU with a REQ/ACK/EOI handshake.
//  On end-of-interrupt, pulses that pin's IRQRES to clear its GPIO latch.
//  Sits between the pin-mux INTR/IRQRES buses and the core's external interrupt input.
// PARAMETERS
//  NUM_PINS        24    number of GPIO interrupt sources (matches `NUM_PINS)
//  ID_W            5     width of IRQ_ID; must satisfy 2**ID_W >= NUM_PINS
//  TIMEOUT_CYCLES  1024  REQ/SERVICE watchdog limit; used only with GPIO_IRQ_TIMEOUT_EN
// PORTS
//  CLK          in   1         system clock, rising edge
//  RST_N        in   1         asynchronous, active-low reset
//  INTR         in   NUM_PINS  level interrupt from each GPIO (held until IRQRES)
//  IRQ_MASK     in   NUM_PINS  1 = source masked (ignored by arbiter)
//  IRQ_REQ      out  1         interrupt request to core
//  IRQ_ID       out  ID_W      index of the requesting pin (0-based)
//  IRQ_ACK      in   1         core accepts request (1-cycle pulse)
//  IRQ_EOI      in   1         core finished servicing (1-cycle pulse)
//  IRQRES       out  NUM_PINS  one-hot 1-cycle clear pulse to the GPIO pins
//  PENDING      out  NUM_PINS  registered INTR & ~IRQ_MASK, for status readback
//  TIMEOUT_ERR  out  1         1-cycle pulse when the watchdog drops an interrupt
// BEHAVIOUR
//  - Reset (RST_N=0, async): state=IDLE, IRQ_REQ=0, IRQ_ID=0, IRQRES=0, PENDING=0,
//    TIMEOUT_ERR=0, rr_ptr=0. Reset mid-handshake abandons it; no IRQRES is issued.
//  - PENDING is registered every cycle: PENDING <= INTR & ~IRQ_MASK.
//  - FSM states: IDLE -> REQ -> SERVICE -> CLEAR -> HOLDOFF -> IDLE.
//  - IDLE: if |PENDING, latch winner = first set bit scanning upward from rr_ptr, wrapping.
//    Go to REQ. IRQ_REQ=1 and IRQ_ID=winner are registered outputs, valid the next cycle.
//    Latency: INTR high at edge t -> PENDING at t+1 -> IRQ_REQ at t+2.
//  - REQ: IRQ_REQ and IRQ_ID held stable until IRQ_ACK=1. On that edge: IRQ_REQ<=0, go to SERVICE.
//    A mask or INTR change while in REQ does not withdraw the request.
//  - SERVICE: wait for IRQ_EOI=1, then go to CLEAR. IRQ_EOI outside SERVICE is ignored.
//    IRQ_ACK outside REQ is ignored. ACK and EOI in the same cycle: only ACK acts.
//  - CLEAR: IRQRES[winner]=1 for exactly one cycle; rr_ptr <= (winner==NUM_PINS-1) ? 0 : winner+1.
//  - HOLDOFF: one idle cycle so GPIO INTR and PENDING deassert; the stale level is never re-granted.
//  - Wrap-around: the scan from rr_ptr covers all NUM_PINS bits modulo NUM_PINS.
//    Every unmasked source is served within NUM_PINS grants.
//  - Masked sources are never granted. All sources masked: stays in IDLE.
//  - IRQ_ID width: zero-extended pin index. Bits >= NUM_PINS are never generated.
// CONFIGURATION
//  Macro GPIO_IRQ_TIMEOUT_EN:
//  - Defined: a cycle counter clears on entering REQ or SERVICE and counts while in either.
//    When it reaches TIMEOUT_CYCLES-1 with no ACK/EOI: IRQ_REQ<=0, TIMEOUT_ERR pulses 1 cycle,
//    FSM goes to CLEAR, so the pin is still cleared and rr_ptr advances.
//  - Undefined: no counter is built, the FSM waits indefinitely, and TIMEOUT_ERR is tied to 0.
// STRUCTURE
//  - Package peripheral_irq_pkg holds:
//    - irq_state_e enum {IDLE, REQ, SERVICE, CLEAR, HOLDOFF};
//    - localparam ID_W default;
//    - function clog2-based id width check.
//  - Sub-module rr_priority_encoder (NUM_PINS, ID_W): combinational.
//    - Inputs: req vector, rr_ptr. Outputs: grant index, any_valid.
//  - Top: FSM, PENDING register, winner/rr_ptr registers, IRQRES decode, optional watchdog.
// TESTING
//  - Reset: RST_N low mid-REQ on pin 5 -> all outputs 0 within same cycle; no IRQRES[5] pulse after release.
//  - Single source: INTR[3]=1 at t -> IRQ_REQ=1, IRQ_ID=3 at t+2.
//    ACK, then EOI -> IRQRES=24'h000008 for one cycle; IRQ_REQ stays 0 afterwards.
//  - Round-robin: INTR[0], INTR[7] and INTR[23] held high, each cleared only by its IRQRES.
//    Successive grants are 0, 7, 23, then wrap, with rr_ptr=0 after 23.
//  - Mask: IRQ_MASK[7]=1 with INTR[7]=1 -> no REQ. Unmask -> REQ with ID=7.
//    Masking during REQ -> request held until ACK.
//  - Protocol abuse: EOI pulsed while in REQ -> ignored, stays REQ. ACK+EOI same cycle -> SERVICE only.
//  - GPIO_IRQ_TIMEOUT_EN, TIMEOUT_CYCLES=16: no ACK for 16 cycles -> TIMEOUT_ERR pulse, IRQRES[id] pulse.
//    Next pending pin is granted; without the macro, REQ is held after 100 cycles.

Source files
------------

// File: rtl/peripheral_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_irq_pkg
// Purpose  : Shared state encoding, default widths and parameter sanity helper
//            for the GPIO interrupt arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package peripheral_irq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        SERVICE = 3'd2,
        CLEAR   = 3'd3,
        HOLDOFF = 3'd4
    } irq_state_e;

    localparam int c_id_w_default = 5;

    function automatic bit id_width_ok(input int num_pins, input int id_w);
        return (id_w >= $clog2(num_pins));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_encoder
// Purpose  : Combinational round-robin picker: first set request bit at or
//            above rr_ptr, wrapping modulo NUM_PINS.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_encoder
    import peripheral_irq_pkg::*;
#(
    parameter int NUM_PINS = 24,
    parameter int ID_W     = c_id_w_default
) (
    input  logic [NUM_PINS-1:0] req,
    input  logic [ID_W-1:0]     rr_ptr,
    output logic [ID_W-1:0]     grant,
    output logic                any_valid
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest hit overwrites last.
    always_comb begin
        grant = '0;
        w_sum = '0;
        w_idx = '0;
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            w_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (w_sum >= (ID_W+1)'(NUM_PINS)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_PINS);
            end
            w_idx = w_sum[ID_W-1:0];
            if (req[w_idx]) begin
                grant = w_idx;
            end
        end
    end

    assign any_valid = |req;

endmodule
`default_nettype wire

// File: rtl/gpio_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpio_irq_arbiter
// Purpose  : Round-robin arbiter presenting GPIO interrupts to the core with a
//            REQ/ACK/EOI handshake and a one-hot IRQRES clear pulse.
//            Optional watchdog enabled by macro GPIO_IRQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_irq_arbiter
    import peripheral_irq_pkg::*;
#(
    parameter int NUM_PINS       = 24,
    parameter int ID_W           = c_id_w_default,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PINS-1:0] intr,
    input  logic [NUM_PINS-1:0] irq_mask,
    output logic                irq_req,
    output logic [ID_W-1:0]     irq_id,
    input  logic                irq_ack,
    input  logic                irq_eoi,
    output logic [NUM_PINS-1:0] irqres,
    output logic [NUM_PINS-1:0] pending,
    output logic                timeout_err
);

    if (!id_width_ok(NUM_PINS, ID_W)) begin : g_bad_id_w
        $error("gpio_irq_arbiter: ID_W too narrow for NUM_PINS");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("gpio_irq_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    irq_state_e          r_state;
    irq_state_e          w_state_nxt;
    logic [NUM_PINS-1:0] r_pending;
    logic                r_irq_req;
    logic                w_irq_req_nxt;
    logic [ID_W-1:0]     r_irq_id;
    logic [ID_W-1:0]     w_irq_id_nxt;
    logic [ID_W-1:0]     r_winner;
    logic [ID_W-1:0]     w_winner_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     w_rr_ptr_nxt;
    logic [ID_W-1:0]     w_grant;
    logic                w_any;
    logic                w_timeout;

    rr_priority_encoder #(
        .NUM_PINS (NUM_PINS),
        .ID_W     (ID_W)
    ) u_rr_enc (
        .req       (r_pending),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .any_valid (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_irq_req <= 1'b0;
            r_irq_id  <= '0;
            r_winner  <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= intr & ~irq_mask;
            r_irq_req <= w_irq_req_nxt;
            r_irq_id  <= w_irq_id_nxt;
            r_winner  <= w_winner_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
        end
    end

    // ACK is tested before EOI/timeout so a same-cycle ACK+EOI only advances to SERVICE.
    always_comb begin
        w_state_nxt   = r_state;
        w_irq_req_nxt = r_irq_req;
        w_irq_id_nxt  = r_irq_id;
        w_winner_nxt  = r_winner;
        w_rr_ptr_nxt  = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt   = REQ;
                    w_irq_req_nxt = 1'b1;
                    w_irq_id_nxt  = w_grant;
                    w_winner_nxt  = w_grant;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    w_irq_req_nxt = 1'b0;
                    w_state_nxt   = SERVICE;
                end else if (w_timeout) begin
                    w_irq_req_nxt = 1'b0;
                    w_state_nxt   = CLEAR;
                end
            end
            SERVICE: begin
                if (irq_eoi || w_timeout) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_rr_ptr_nxt = (r_winner == ID_W'(NUM_PINS - 1)) ? '0 : r_winner + ID_W'(1);
                w_state_nxt  = HOLDOFF;
            end
            HOLDOFF: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_irq_req_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        irqres = '0;
        if (r_state == CLEAR) begin
            irqres[r_winner] = 1'b1;
        end
    end

    assign pending = r_pending;
    assign irq_req = r_irq_req;
    assign irq_id  = r_irq_id;

`ifdef GPIO_IRQ_TIMEOUT_EN
    localparam int c_wd_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_wd_w-1:0] r_wd_cnt;
    logic              r_timeout_err;
    logic              w_wd_active;

    assign w_wd_active = (r_state == REQ) || (r_state == SERVICE);
    assign w_timeout   = w_wd_active && (r_wd_cnt == c_wd_w'(TIMEOUT_CYCLES - 1));

    // Any state change restarts the count, covering entry into REQ and SERVICE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout &&
                             !((r_state == REQ && irq_ack) || (r_state == SERVICE && irq_eoi));
            if (w_state_nxt != r_state) begin
                r_wd_cnt <= '0;
            end else if (w_wd_active) begin
                r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpio_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_irq_arbiter
// Purpose  : Self-checking bench for gpio_irq_arbiter with a GPIO latch model
//            and an expected-grant queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_irq_arbiter;

    localparam int NP = 24;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] intr;
    logic [NP-1:0] irq_mask = '0;
    logic          irq_req;
    logic [IW-1:0] irq_id;
    logic          irq_ack = 1'b0;
    logic          irq_eoi = 1'b0;
    logic [NP-1:0] irqres;
    logic [NP-1:0] pending;
    logic          timeout_err;
    logic [NP-1:0] set_bits = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    typedef struct packed {
        logic [NP-1:0]      set_bits;
        logic [NP-1:0]      mask;
        logic [1:0]         n;
        logic [2:0][IW-1:0] exp;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    gpio_irq_arbiter #(
        .NUM_PINS       (NP),
        .ID_W           (IW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .intr        (intr),
        .irq_mask    (irq_mask),
        .irq_req     (irq_req),
        .irq_id      (irq_id),
        .irq_ack     (irq_ack),
        .irq_eoi     (irq_eoi),
        .irqres      (irqres),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    // GPIO latch: bits set by stimulus, held until their IRQRES pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) intr <= '0;
        else        intr <= (intr | set_bits) & ~irqres;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NP-1:0] s, input logic [NP-1:0] m,
                                input logic [1:0] n, input int e0, input int e1, input int e2);
        vec_t v;
        v.set_bits = s;
        v.mask     = m;
        v.n        = n;
        v.exp[0]   = IW'(e0);
        v.exp[1]   = IW'(e1);
        v.exp[2]   = IW'(e2);
        return v;
    endfunction

    function automatic logic [NP-1:0] bit_of(input int p);
        logic [NP-1:0] one;
        one = NP'(1);
        return one << p;
    endfunction

    task automatic raise(input logic [NP-1:0] b);
        set_bits = b;
        @(negedge clk);
        set_bits = '0;
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (irq_req) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic serve_next(input string tag);
        bit got;
        int exp;
        wait_req(got);
        chk({tag, "_req_seen"}, 32'(got), 32'd1);
        if (!got) return;
        chk({tag, "_queue"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() == 0) return;
        exp = exp_q.pop_front();
        chk({tag, "_id"}, 32'(irq_id), 32'(exp));
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk({tag, "_req_drop"}, 32'(irq_req), 32'd0);
        irq_eoi = 1'b1;
        @(negedge clk);
        irq_eoi = 1'b0;
        chk({tag, "_irqres"}, 32'(irqres), 32'(bit_of(exp)));
        @(negedge clk);
        chk({tag, "_irqres_end"}, 32'({irq_req, irqres}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

    initial begin
        bit got;
        bit bad;
        int cyc;

        tbl[0] = mk(bit_of(0) | bit_of(7) | bit_of(23), '0, 2'd3, 0, 7, 23);
        tbl[1] = mk(bit_of(1) | bit_of(2), '0, 2'd2, 1, 2, 0);
        tbl[2] = mk(bit_of(2) | bit_of(5) | bit_of(20), bit_of(5), 2'd2, 20, 2, 0);
        tbl[3] = mk('0, '0, 2'd1, 5, 0, 0);
        tbl[4] = mk(bit_of(6) | bit_of(23), '0, 2'd2, 6, 23, 0);
        tbl[5] = mk(bit_of(3) | bit_of(10), bit_of(3) | bit_of(10), 2'd0, 0, 0, 0);
        tbl[6] = mk('0, bit_of(10), 2'd1, 3, 0, 0);
        tbl[7] = mk('0, '0, 2'd1, 10, 0, 0);
        tbl[8] = mk(bit_of(4) | bit_of(11) | bit_of(12), '0, 2'd3, 11, 12, 4);

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req", 32'(irq_req), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        chk("rst_irqres", 32'(irqres), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);

        // Single source latency: INTR -> PENDING one edge later -> REQ one more
        raise(bit_of(3));
        chk("lat_pend_t0", 32'(pending), 32'd0);
        @(negedge clk);
        chk("lat_pend_t1", 32'(pending), 32'h000008);
        chk("lat_req_t1", 32'(irq_req), 32'd0);
        @(negedge clk);
        chk("lat_req_t2", 32'(irq_req), 32'd1);
        chk("lat_id_t2", 32'(irq_id), 32'd3);
        exp_q.push_back(3);
        serve_next("single3");

        // Reset mid-REQ on pin 5
        raise(bit_of(5));
        wait_req(got);
        chk("rmid_req", 32'(got), 32'd1);
        chk("rmid_id", 32'(irq_id), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_async_out", 32'({irq_req, irq_id, irqres, timeout_err}), 32'd0);
        chk("rmid_async_pend", 32'(pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (irqres != '0 || irq_req) bad = 1'b1;
        end
        chk("rmid_no_irqres", 32'(bad), 32'd0);

        // Round-robin / mask vector table, rr_ptr starts at 0
        for (int r = 0; r < 9; r++) begin
            irq_mask = tbl[r].mask;
            raise(tbl[r].set_bits);
            for (int j = 0; j < int'(tbl[r].n); j++) exp_q.push_back(int'(tbl[r].exp[j]));
            if (tbl[r].n == 2'd0) begin
                bad = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (irq_req) bad = 1'b1;
                end
                chk($sformatf("vec%0d_no_req", r), 32'(bad), 32'd0);
                chk($sformatf("vec%0d_pending", r), 32'(pending), 32'd0);
            end else begin
                for (int j = 0; j < int'(tbl[r].n); j++) serve_next($sformatf("vec%0d_g%0d", r, j));
            end
        end

        // Masked source is ignored until unmasked (rr_ptr = 5)
        irq_mask = bit_of(7);
        raise(bit_of(7));
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (irq_req) bad = 1'b1;
        end
        chk("mask7_no_req", 32'(bad), 32'd0);
        irq_mask = '0;
        exp_q.push_back(7);
        serve_next("unmask7");

        // Masking during REQ does not withdraw it
        raise(bit_of(9));
        wait_req(got);
        irq_mask = bit_of(9);
        repeat (3) @(negedge clk);
        chk("maskreq_held", 32'({irq_req, irq_id}), 32'({1'b1, 5'd9}));
        exp_q.push_back(9);
        serve_next("maskreq9");
        irq_mask = '0;

        // Protocol abuse: EOI in REQ ignored; ACK+EOI together only acks
        raise(bit_of(12));
        wait_req(got);
        chk("abuse_id", 32'(irq_id), 32'd12);
        irq_eoi = 1'b1;
        @(negedge clk);
        irq_eoi = 1'b0;
        @(negedge clk);
        chk("abuse_eoi_in_req", 32'({irq_req, irqres}), 32'({1'b1, 24'h0}));
        irq_ack = 1'b1;
        irq_eoi = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        irq_eoi = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (irqres != '0 || irq_req) bad = 1'b1;
        end
        chk("abuse_ackeoi_service", 32'(bad), 32'd0);
        irq_eoi = 1'b1;
        @(negedge clk);
        irq_eoi = 1'b0;
        chk("abuse_irqres", 32'(irqres), 32'(bit_of(12)));
        @(negedge clk);

`ifdef GPIO_IRQ_TIMEOUT_EN
        // Watchdog drops pin 14 after 16 REQ cycles, then grants pin 16
        raise(bit_of(14) | bit_of(16));
        wait_req(got);
        chk("to_id", 32'(irq_id), 32'd14);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (timeout_err) break;
        end
        chk("to_cycles", 32'(cyc), 32'd16);
        chk("to_irqres", 32'(irqres), 32'(bit_of(14)));
        chk("to_req_drop", 32'(irq_req), 32'd0);
        @(negedge clk);
        chk("to_pulse_end", 32'(timeout_err), 32'd0);
        exp_q.push_back(16);
        serve_next("to_next16");
`else
        // No watchdog: REQ held indefinitely
        raise(bit_of(14));
        wait_req(got);
        chk("hold_id", 32'(irq_id), 32'd14);
        cyc = 0;
        repeat (100) begin
            @(negedge clk);
            if (irq_req && !timeout_err) cyc++;
        end
        chk("hold_100", 32'(cyc), 32'd100);
        exp_q.push_back(14);
        serve_next("hold14");
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
